// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle integer-core controller.
// Enum encodings are fixed because alu_op leaves the block as a raw 4-bit code.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_ZERO  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

endpackage

// File: rtl/multicycle_ctrl_opdecode.sv
// Combinational instruction classifier: turns opcode/funct3/funct7 into ALU
// controls plus a legality flag. The FSM decides when to capture the result.
module ctrl_opdecode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       op_a_pc,
    output logic       op_b_imm,
    output logic       imm_u,
    output logic       legal
);

    alu_op_t f3_op;
    alu_op_t op_sel;
    logic    f7_zero;
    logic    f7_alt;

    assign f7_zero = (funct7 == F7_ZERO);
    assign f7_alt  = (funct7 == F7_ALT);
    assign alu_op  = op_sel;

    // funct3 mapping shared by R and I types; only SRL/SRA looks at funct7 here.
    always_comb begin
        f3_op = ALU_ADD;
        case (funct3)
            3'b000: f3_op = ALU_ADD;
            3'b001: f3_op = ALU_SLL;
            3'b010: f3_op = ALU_SLT;
            3'b011: f3_op = ALU_SLTU;
            3'b100: f3_op = ALU_XOR;
            3'b101: f3_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: f3_op = ALU_OR;
            3'b111: f3_op = ALU_AND;
            default: f3_op = ALU_ADD;
        endcase
    end

    always_comb begin
        op_sel   = ALU_ADD;
        op_a_pc  = 1'b0;
        op_b_imm = 1'b0;
        imm_u    = 1'b0;
        legal    = 1'b0;
        case (opcode)
            OP_R: begin
                legal  = f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
                op_sel = (funct3 == 3'b000 && funct7[5]) ? ALU_SUB : f3_op;
            end
            OP_I: begin
                // funct7 is really imm[11:5]; it only matters for the shifts.
                op_b_imm = 1'b1;
                op_sel   = f3_op;
                case (funct3)
                    3'b001:  legal = f7_zero;
                    3'b101:  legal = f7_zero || f7_alt;
                    default: legal = 1'b1;
                endcase
            end
            OP_LUI: begin
                op_sel   = ALU_PASSB;
                op_b_imm = 1'b1;
                imm_u    = 1'b1;
                legal    = 1'b1;
            end
            OP_AUIPC: begin
                op_sel   = ALU_ADD;
                op_a_pc  = 1'b1;
                op_b_imm = 1'b1;
                imm_u    = 1'b1;
                legal    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> WB per instruction,
// with a fetch timeout, sticky error flags and a retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic [3:0]       alu_op,
    output logic             op_a_pc,
    output logic             op_b_imm,
    output logic             imm_u,
    output logic             reg_we,
    output logic             pc_en,
    output logic             busy,
    output logic             illegal,
    output logic             fetch_err,
    output logic [CNT_W-1:0] retired
);

    localparam int TO_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam int TO_LAST = (FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST_V = TO_W'(TO_LAST);

    state_t           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    alu_op_t          alu_op_q, alu_op_d;
    logic             op_a_pc_q, op_a_pc_d;
    logic             op_b_imm_q, op_b_imm_d;
    logic             imm_u_q, imm_u_d;
    logic             illegal_q, illegal_d;
    logic             fetch_err_q, fetch_err_d;

    logic [3:0]       dec_alu_op;
    logic             dec_a_pc;
    logic             dec_b_imm;
    logic             dec_imm_u;
    logic             dec_legal;

    ctrl_opdecode u_opdecode (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_op   (dec_alu_op),
        .op_a_pc  (dec_a_pc),
        .op_b_imm (dec_b_imm),
        .imm_u    (dec_imm_u),
        .legal    (dec_legal)
    );

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        retired_d   = retired_q;
        alu_op_d    = alu_op_q;
        op_a_pc_d   = op_a_pc_q;
        op_b_imm_d  = op_b_imm_q;
        imm_u_d     = imm_u_q;
        illegal_d   = illegal_q;
        fetch_err_d = fetch_err_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    state_d  = DECODE;
                    to_cnt_d = '0;
                end else if (FETCH_TIMEOUT != 0) begin
                    if (to_cnt_q == TO_LAST_V) begin
                        fetch_err_d = 1'b1;
                        state_d     = TRAP;
                        to_cnt_d    = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            DECODE: begin
                if (dec_legal) begin
                    alu_op_d   = alu_op_t'(dec_alu_op);
                    op_a_pc_d  = dec_a_pc;
                    op_b_imm_d = dec_b_imm;
                    imm_u_d    = dec_imm_u;
                    state_d    = EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                // Controls drop back to zero once the instruction retires.
                retired_d  = retired_q + CNT_W'(1);
                alu_op_d   = ALU_ADD;
                op_a_pc_d  = 1'b0;
                op_b_imm_d = 1'b0;
                imm_u_d    = 1'b0;
                state_d    = run ? FETCH : IDLE;
            end
            TRAP: state_d = TRAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            to_cnt_q    <= '0;
            retired_q   <= '0;
            alu_op_q    <= ALU_ADD;
            op_a_pc_q   <= 1'b0;
            op_b_imm_q  <= 1'b0;
            imm_u_q     <= 1'b0;
            illegal_q   <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            retired_q   <= retired_d;
            alu_op_q    <= alu_op_d;
            op_a_pc_q   <= op_a_pc_d;
            op_b_imm_q  <= op_b_imm_d;
            imm_u_q     <= imm_u_d;
            illegal_q   <= illegal_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign ir_load   = (state_q == FETCH) && imem_ack;
    assign reg_we    = (state_q == WB);
    assign pc_en     = (state_q == WB);
    assign busy      = (state_q != IDLE) && (state_q != TRAP);
    assign alu_op    = alu_op_q;
    assign op_a_pc   = op_a_pc_q;
    assign op_b_imm  = op_b_imm_q;
    assign imm_u     = imm_u_q;
    assign illegal   = illegal_q;
    assign fetch_err = fetch_err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction sequencing, legality,
// trap behaviour, fetch timeout (enabled and disabled) and reset.
module tb_multicycle_ctrl;

  localparam logic [3:0] A_ADD   = 4'd0;
  localparam logic [3:0] A_SUB   = 4'd1;
  localparam logic [3:0] A_SRA   = 4'd7;
  localparam logic [3:0] A_PASSB = 4'd10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic        ack0 = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;

  logic        imem_req, ir_load, op_a_pc, op_b_imm, imm_u, reg_we, pc_en;
  logic        busy, illegal, fetch_err;
  logic [3:0]  alu_op;
  logic [31:0] retired;

  logic        imem_req0, ir_load0, op_a_pc0, op_b_imm0, imm_u0, reg_we0, pc_en0;
  logic        busy0, illegal0, fetch_err0;
  logic [3:0]  alu_op0;
  logic [31:0] retired0;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          wb_cyc = 0;
  int          prev_wb_cyc = 0;
  logic [31:0] exp_retired = '0;

  multicycle_ctrl #(.CNT_W(32), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_req(imem_req), .imem_ack(imem_ack),
    .ir_load(ir_load), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_op(alu_op), .op_a_pc(op_a_pc), .op_b_imm(op_b_imm), .imm_u(imm_u),
    .reg_we(reg_we), .pc_en(pc_en), .busy(busy), .illegal(illegal),
    .fetch_err(fetch_err), .retired(retired)
  );

  multicycle_ctrl #(.CNT_W(32), .FETCH_TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .run(run), .imem_req(imem_req0), .imem_ack(ack0),
    .ir_load(ir_load0), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_op(alu_op0), .op_a_pc(op_a_pc0), .op_b_imm(op_b_imm0), .imm_u(imm_u0),
    .reg_we(reg_we0), .pc_en(pc_en0), .busy(busy0), .illegal(illegal0),
    .fetch_err(fetch_err0), .retired(retired0)
  );

  // clock / cycle bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (reg_we) we_cnt <= we_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] ins);
    opcode = ins[6:0];
    funct3 = ins[14:12];
    funct7 = ins[31:25];
  endtask

  // Entered with the DUT in FETCH; leaves one cycle after WB.
  task automatic do_instr(input logic [31:0] ins, input int ack_delay,
                          input logic [3:0] e_alu, input logic e_apc,
                          input logic e_bimm, input logic e_immu, input bit drop_run);
    check("fetch_req", 32'(imem_req), 1);
    for (int i = 0; i < ack_delay; i++) begin
      imem_ack = 1'b0;
      #1;
      check("wait_no_ir_load", 32'(ir_load), 0);
      tick();
      check("wait_req", 32'(imem_req), 1);
    end
    imem_ack = 1'b1;
    #1;
    check("ir_load", 32'(ir_load), 1);
    tick();
    imem_ack = 1'b0;
    set_ir(ins);
    check("decode_busy", 32'(busy), 1);
    check("decode_we", 32'(reg_we), 0);
    tick();
    if (drop_run) run = 1'b0;
    check("exec_alu_op", 32'(alu_op), 32'(e_alu));
    check("exec_op_a_pc", 32'(op_a_pc), 32'(e_apc));
    check("exec_op_b_imm", 32'(op_b_imm), 32'(e_bimm));
    check("exec_imm_u", 32'(imm_u), 32'(e_immu));
    check("exec_we", 32'(reg_we), 0);
    tick();
    prev_wb_cyc = wb_cyc;
    wb_cyc = cyc;
    check("wb_we", 32'(reg_we), 1);
    check("wb_pc_en", 32'(pc_en), 1);
    check("wb_alu_op", 32'(alu_op), 32'(e_alu));
    check("wb_retired", retired, exp_retired);
    tick();
    exp_retired = exp_retired + 1;
    check("retired", retired, exp_retired);
    check("post_we", 32'(reg_we), 0);
    if (run) begin
      check("next_fetch", 32'(imem_req), 1);
    end else begin
      check("idle_busy", 32'(busy), 0);
      check("idle_req", 32'(imem_req), 0);
      check("idle_alu_op", 32'(alu_op), 32'(A_ADD));
      check("idle_op_b_imm", 32'(op_b_imm), 0);
    end
  endtask

  initial begin
    logic [31:0] bad_ins [2];
    int          we0;
    int          n_req;

    bad_ins[0] = 32'h0000_007F;
    bad_ins[1] = 32'h4000_1033;

    // reset state
    repeat (3) tick();
    check("rst_req", 32'(imem_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_retired", retired, 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_fetch_err", 32'(fetch_err), 0);
    check("rst_alu_op", 32'(alu_op), 32'(A_ADD));
    check("rst_we", 32'(reg_we), 0);

    // ack while IDLE is ignored
    reset = 1'b0;
    imem_ack = 1'b1;
    tick();
    check("idle_ack_req", 32'(imem_req), 0);
    check("idle_ack_ir_load", 32'(ir_load), 0);
    imem_ack = 1'b0;

    run = 1'b1;
    tick();
    do_instr(32'h0020_81B3, 0, A_ADD,   1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h4020_81B3, 0, A_SUB,   1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h4030_D093, 0, A_SRA,   1'b0, 1'b1, 1'b0, 1'b0);
    check("wb_spacing", 32'(wb_cyc - prev_wb_cyc), 4);
    do_instr(32'h1234_52B7, 3, A_PASSB, 1'b0, 1'b1, 1'b1, 1'b0);
    do_instr(32'h0000_0297, 0, A_ADD,   1'b1, 1'b1, 1'b1, 1'b0);
    do_instr(32'h0050_0093, 0, A_ADD,   1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check("stay_idle", 32'(imem_req), 0);

    // reset in the middle of a fetch
    run = 1'b1;
    tick();
    check("refetch_req", 32'(imem_req), 1);
    reset = 1'b1;
    tick();
    check("midfetch_rst_req", 32'(imem_req), 0);
    check("midfetch_rst_retired", retired, 0);
    check("midfetch_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    run = 1'b0;
    exp_retired = '0;
    tick();

    // illegal instructions trap and ignore run
    for (int k = 0; k < 2; k++) begin
      we0 = we_cnt;
      run = 1'b1;
      tick();
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      set_ir(bad_ins[k]);
      tick();
      check("trap_illegal", 32'(illegal), 1);
      check("trap_busy", 32'(busy), 0);
      check("trap_req", 32'(imem_req), 0);
      for (int i = 0; i < 6; i++) begin
        run = ~run;
        imem_ack = i[0];
        tick();
        check("trap_hold_req", 32'(imem_req), 0);
        check("trap_hold_illegal", 32'(illegal), 1);
      end
      check("trap_no_we", 32'(we_cnt - we0), 0);
      check("trap_retired", retired, 0);
      reset = 1'b1;
      tick();
      check("trap_rst_illegal", 32'(illegal), 0);
      reset = 1'b0;
      run = 1'b0;
      imem_ack = 1'b0;
      tick();
    end

    // fetch timeout
    run = 1'b1;
    tick();
    n_req = 0;
    for (int i = 0; i < 40 && !fetch_err; i++) begin
      if (imem_req) n_req++;
      tick();
    end
    check("timeout_req_cycles", 32'(n_req), 16);
    check("timeout_fetch_err", 32'(fetch_err), 1);
    check("timeout_req_low", 32'(imem_req), 0);
    check("timeout_busy", 32'(busy), 0);
    repeat (12) tick();
    check("timeout_stays_trap", 32'(imem_req), 0);
    check("no_timeout_req", 32'(imem_req0), 1);
    check("no_timeout_err", 32'(fetch_err0), 0);
    check("no_timeout_busy", 32'(busy0), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
